dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipelined core's M stage. It accepts the controller's data-memory requests (MemWriteM, MemtoRegM, ByteMaskM) together with address and store data.
- Services them over a single-outstanding valid/ready backing bus, and asserts MemStallM to the hazard unit while a request is incomplete.
- A one-entry posted write buffer lets most stores complete without stalling. A load that fully hits the buffer is forwarded without a bus access.

Parameters:
- ADDR_W, 32, byte-address width; bus carries word address [ADDR_W-1:2].
- DATA_W, 32, data width; byte-enable width is DATA_W/8 (4).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store request (already condition-gated).
- MemtoRegM  in  1  load request.
- ByteMaskM  in  4  byte lanes for the store or load.
- DataAdrM  in  32  byte address (ALUResultM).
- WriteDataM  in  32  store data, already lane-replicated.
- ReadDataM  out  32  registered load word; valid in the cycle MemStallM falls for a load.
- MemStallM  out  1  hold M stage and everything upstream.
- BusReqValid  out  1  bus request valid.
- BusReqReady  in  1  bus accepts request.
- BusWrite  out  1  1=write, 0=read.
- BusAdr  out  30  word address.
- BusWData  out  32  write data.
- BusByteEn  out  4  write byte enables (4'hF on reads).
- BusRespValid  in  1  read data valid.
- BusRData  in  32  read data.

Behaviour:
- Reset (reset=0, async):
  - FSM state = IDLE; wb_valid = 0.
  - ReadDataM = 0; MemStallM = 0; BusReqValid = 0.
  - BusWrite, BusAdr, BusWData = 0; BusByteEn = 0.
- Request handling:
  - MemWriteM and MemtoRegM together is illegal; behaviour is undefined.
  - Request inputs are held stable by the hazard unit while MemStallM=1.
- Write buffer: one entry {wb_valid, wb_adr[31:2], wb_data, wb_mask}.
- Store:
  - wb_valid=0: the entry is captured at the clock edge and MemStallM=0 in that cycle.
  - wb_valid=1: MemStallM=1, including the cycle in which the drain handshake completes. The store is captured in the first cycle it is presented with wb_valid=0.
- Drain:
  - Whenever state=IDLE and wb_valid=1, drive BusReqValid=1, BusWrite=1, BusAdr=wb_adr, BusWData=wb_data, BusByteEn=wb_mask.
  - On the BusReqValid&BusReqReady edge, wb_valid is cleared. Writes return no response.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
- IDLE with MemtoRegM=1, MemStallM=1:
  - Full hit (wb_valid, wb_adr==DataAdrM[31:2], wb_mask==4'hF): ReadDataM<=wb_data, go to RD_DONE. A drain may complete in the same cycle.
  - Otherwise, if wb_valid: stay in IDLE until the drain completes.
  - Otherwise: go to RD_REQ.
- RD_REQ:
  - BusReqValid=1, BusWrite=0, BusAdr=DataAdrM[31:2], BusByteEn=4'hF.
  - Hold all of these stable until BusReqReady; on the handshake go to RD_WAIT.
  - If BusRespValid arrives in the same cycle as the handshake, latch BusRData and go directly to RD_DONE.
- RD_WAIT: on BusRespValid, ReadDataM<=BusRData and go to RD_DONE. The wait is unbounded.
- RD_DONE: MemStallM=0 for exactly this one cycle so the pipeline advances, then return to IDLE. The drain is not issued in RD_DONE.
- MemStallM (combinational):
  - (MemtoRegM & state!=RD_DONE) | (MemWriteM & wb_valid).
  - MemStallM=0 when no request is present.
- ReadDataM holds its value until the next load latch; it is not cleared after use.
- Exactly one bus transaction is outstanding at a time. BusRespValid outside RD_REQ/RD_WAIT is ignored.
- Reset mid-operation aborts the read and discards the buffered store. A stale bus response after reset is ignored by rule above.
- Minimum latencies:
  - Store: 0 stall cycles.
  - Buffer-hit load: 1 stall cycle.
  - Bus load with ready=1 and response one cycle later: 3 stall cycles.

Test Plan:
- Reset, then a store to 0x100 with data 0xDEADBEEF, mask 4'hF on an idle bus → MemStallM=0; next cycle BusReqValid=1, BusWrite=1, BusAdr=0x40, BusByteEn=4'hF.
- Back-to-back stores to 0x100 then 0x104, with BusReqReady held 0 for 3 cycles → the second store stalls 4 cycles; BusAdr=0x41 is issued after the first drain.
- Load from 0x200 on an empty buffer, ready=1, BusRData=0x12345678 one cycle later → MemStallM high for 3 cycles; ReadDataM=0x12345678 in the cycle the stall falls.
- Store 0xCAFEF00D to 0x300 with mask 4'hF, then an immediate load from 0x300 while ready=0 → 1 stall cycle, ReadDataM=0xCAFEF00D, no bus read issued.
- Store with mask 4'b0011, then a load to the same word → the drain completes first, then a bus read is issued; no forwarding occurs.
- Assert reset while in RD_WAIT, then send a stale BusRespValid → all outputs at reset values, ReadDataM=0, state IDLE.

Source files
------------

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: posted one-entry store buffer,
// full-word load forwarding and a single-outstanding backing bus.
module dmem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic                   MemtoRegM,
  input  logic [DATA_W/8-1:0]    ByteMaskM,
  input  logic [ADDR_W-1:0]      DataAdrM,
  input  logic [DATA_W-1:0]      WriteDataM,
  output logic [DATA_W-1:0]      ReadDataM,
  output logic                   MemStallM,
  output logic                   BusReqValid,
  input  logic                   BusReqReady,
  output logic                   BusWrite,
  output logic [ADDR_W-3:0]      BusAdr,
  output logic [DATA_W-1:0]      BusWData,
  output logic [DATA_W/8-1:0]    BusByteEn,
  input  logic                   BusRespValid,
  input  logic [DATA_W-1:0]      BusRData
);

  localparam int BE_W = DATA_W / 8;
  localparam int AW   = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE, RD_REQ, RD_WAIT, RD_DONE
  } state_t;

  state_t              r_state;
  logic                r_wb_valid;
  logic [AW-1:0]       r_wb_adr;
  logic [DATA_W-1:0]   r_wb_data;
  logic [BE_W-1:0]     r_wb_mask;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_drain;
  logic                w_rdreq;
  logic                w_hit;
  logic                w_unused;

  assign w_drain  = (r_state == IDLE) && r_wb_valid;
  assign w_rdreq  = (r_state == RD_REQ);
  assign w_hit    = r_wb_valid
                 && (r_wb_adr == DataAdrM[ADDR_W-1:2])
                 && (r_wb_mask == {BE_W{1'b1}});
  assign w_unused = ^DataAdrM[1:0];

  assign ReadDataM = r_rdata;
  assign MemStallM = (MemtoRegM && (r_state != RD_DONE))
                  || (MemWriteM && r_wb_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wb_valid <= 1'b0;
      r_wb_adr   <= '0;
      r_wb_data  <= '0;
      r_wb_mask  <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_drain && BusReqReady)
        r_wb_valid <= 1'b0;
      if (MemWriteM && !r_wb_valid) begin
        r_wb_valid <= 1'b1;
        r_wb_adr   <= DataAdrM[ADDR_W-1:2];
        r_wb_data  <= WriteDataM;
        r_wb_mask  <= ByteMaskM;
      end
      unique case (r_state)
        IDLE: begin
          // partial-mask hits wait for the drain, then read the bus
          if (MemtoRegM) begin
            if (w_hit) begin
              r_rdata <= r_wb_data;
              r_state <= RD_DONE;
            end else if (!r_wb_valid) begin
              r_state <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (BusReqReady) begin
            if (BusRespValid) begin
              r_rdata <= BusRData;
              r_state <= RD_DONE;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (BusRespValid) begin
            r_rdata <= BusRData;
            r_state <= RD_DONE;
          end
        end
        RD_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    BusReqValid = 1'b0;
    BusWrite    = 1'b0;
    BusAdr      = '0;
    BusWData    = '0;
    BusByteEn   = '0;
    unique case (1'b1)
      w_drain: begin
        BusReqValid = 1'b1;
        BusWrite    = 1'b1;
        BusAdr      = r_wb_adr;
        BusWData    = r_wb_data;
        BusByteEn   = r_wb_mask;
      end
      w_rdreq: begin
        BusReqValid = 1'b1;
        BusAdr      = DataAdrM[ADDR_W-1:2];
        BusByteEn   = {BE_W{1'b1}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: bus slave with backing memory,
// directed latency cases and a randomized load/store mix.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [3:0]  ByteMaskM;
  logic [31:0] DataAdrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        BusReqValid, BusReqReady, BusWrite;
  logic [29:0] BusAdr;
  logic [31:0] BusWData;
  logic [3:0]  BusByteEn;
  logic        BusRespValid;
  logic [31:0] BusRData;

  dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ByteMaskM(ByteMaskM), .DataAdrM(DataAdrM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .MemStallM(MemStallM), .BusReqValid(BusReqValid),
    .BusReqReady(BusReqReady), .BusWrite(BusWrite),
    .BusAdr(BusAdr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusRespValid(BusRespValid),
    .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] smem[int];
  logic [31:0] rmem[int];

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rget(input int a);
    return rmem.exists(a) ? rmem[a] : 32'h0;
  endfunction

  // bus slave knobs
  int   hold_cnt = 0;
  bit   force_nrdy = 0;
  bit   ready_rand = 0;
  bit   rsp_rand = 0;
  int   rsp_fix = 1;
  int   rd_cnt = 0;
  bit   pend = 0;
  int   pend_cnt = 0;
  logic [31:0] pend_d;
  int   sa, dly;
  wr_t  e;

  initial begin
    BusReqReady  = 1'b0;
    BusRespValid = 1'b0;
    BusRData     = '0;
    forever begin
      @(negedge clk);
      BusRespValid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          BusRespValid = 1'b1;
          BusRData = pend_d;
          pend = 0;
        end
      end
      if (BusReqValid && hold_cnt > 0) begin
        BusReqReady = 1'b0;
        hold_cnt--;
      end else if (force_nrdy)
        BusReqReady = 1'b0;
      else if (ready_rand)
        BusReqReady = 1'($urandom % 2);
      else
        BusReqReady = 1'b1;
      if (reset && BusReqValid && BusReqReady) begin
        sa = int'(BusAdr);
        if (BusWrite) begin
          if (wq.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            e = wq.pop_front();
            chk("wr_adr", 32'(BusAdr), 32'(e.a));
            chk("wr_data", BusWData, e.d);
            chk("wr_mask", 32'(BusByteEn), 32'(e.m));
            smem[sa] = merge(smem.exists(sa) ? smem[sa] : 0,
                             BusWData, BusByteEn);
          end
        end else begin
          rd_cnt++;
          chk("rd_be", 32'(BusByteEn), 32'hF);
          pend_d = smem.exists(sa) ? smem[sa] : 32'h0;
          dly = rsp_rand ? int'($urandom_range(0, 3)) : rsp_fix;
          if (dly == 0) begin
            BusRespValid = 1'b1;
            BusRData = pend_d;
          end else begin
            pend = 1;
            pend_cnt = dly;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    MemWriteM = 0;
    MemtoRegM = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input bit wr, input bit ld,
                    input logic [31:0] adr, input logic [31:0] d,
                    input logic [3:0] m, output int stalls,
                    output logic [31:0] rdv);
    bit done;
    MemWriteM  = wr;
    MemtoRegM  = ld;
    DataAdrM   = adr;
    WriteDataM = d;
    ByteMaskM  = m;
    stalls = 0;
    done = 0;
    rdv = '0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!MemStallM) begin
        rdv = ReadDataM;
        done = 1;
      end else stalls++;
    end
    if (!done) chk("op_timeout", 1, 0);
    @(posedge clk);
    #1;
    MemWriteM = 0;
    MemtoRegM = 0;
    if (wr) begin
      wq.push_back('{adr[31:2], d, m});
      rmem[int'(adr[31:2])] = merge(rget(int'(adr[31:2])), d, m);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_stall"}, 32'(MemStallM), 0);
    chk({tag, "_valid"}, 32'(BusReqValid), 0);
    chk({tag, "_write"}, 32'(BusWrite), 0);
    chk({tag, "_adr"}, 32'(BusAdr), 0);
    chk({tag, "_wdata"}, BusWData, 0);
    chk({tag, "_be"}, 32'(BusByteEn), 0);
    chk({tag, "_rdata"}, ReadDataM, 0);
  endtask

  int          st, rc, k;
  logic [31:0] rv, adr;
  logic [3:0]  masks [8];

  initial begin
    masks = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h8, 4'h6};
    reset = 0;
    MemWriteM = 0; MemtoRegM = 0;
    ByteMaskM = 0; DataAdrM = 0; WriteDataM = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("reset");
    reset = 1;
    idle(1);

    op(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, st, rv);
    chk("st0_stall", st, 0);
    chk("st0_valid", 32'(BusReqValid), 1);
    chk("st0_write", 32'(BusWrite), 1);
    chk("st0_adr", 32'(BusAdr), 32'h40);
    chk("st0_be", 32'(BusByteEn), 32'hF);
    idle(3);

    hold_cnt = 3;
    op(1, 0, 32'h100, 32'h11111111, 4'hF, st, rv);
    op(1, 0, 32'h104, 32'h22222222, 4'hF, st, rv);
    chk("b2b_stall", st, 4);
    chk("b2b_adr", 32'(BusAdr), 32'h41);
    idle(3);

    smem[32'h80] = 32'h12345678;
    rmem[32'h80] = 32'h12345678;
    op(0, 1, 32'h200, 0, 4'hF, st, rv);
    chk("ld_stall", st, 3);
    chk("ld_data", rv, 32'h12345678);

    force_nrdy = 1;
    rc = rd_cnt;
    op(1, 0, 32'h300, 32'hCAFEF00D, 4'hF, st, rv);
    op(0, 1, 32'h300, 0, 4'hF, st, rv);
    chk("hit_stall", st, 1);
    chk("hit_data", rv, 32'hCAFEF00D);
    chk("hit_nobus", rd_cnt, rc);
    force_nrdy = 0;
    idle(3);

    smem[32'h100] = 32'hAABBCCDD;
    rmem[32'h100] = 32'hAABBCCDD;
    op(1, 0, 32'h400, 32'h11225566, 4'h3, st, rv);
    rc = rd_cnt;
    op(0, 1, 32'h400, 0, 4'hF, st, rv);
    chk("part_stall", st, 4);
    chk("part_data", rv, 32'hAABB5566);
    chk("part_bus", rd_cnt, rc + 1);
    idle(3);

    ready_rand = 1;
    rsp_rand = 1;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom % 3);
      adr = 32'h2000 + 32'(($urandom % 8) * 4);
      if (k == 0)
        op(1, 0, adr, $urandom, masks[$urandom % 8], st, rv);
      else if (k == 1) begin
        op(0, 1, adr, 0, 4'hF, st, rv);
        chk("rnd_ld", rv, rget(int'(adr[31:2])));
      end else
        idle(int'($urandom_range(1, 3)));
    end
    idle(40);
    chk("wq_drained", wq.size(), 0);

    ready_rand = 0;
    rsp_rand = 0;
    rsp_fix = 5;
    MemtoRegM = 1;
    DataAdrM = 32'h200;
    ByteMaskM = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    reset = 0;
    MemtoRegM = 0;
    #1;
    chk_rst("midrst");
    @(posedge clk);
    #1;
    reset = 1;
    idle(8);
    chk_rst("stale");
    rsp_fix = 1;
    op(0, 1, 32'h200, 0, 4'hF, st, rv);
    chk("postrst_stall", st, 3);
    chk("postrst_data", rv, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
